// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed active-low 7-segment bus: recovers each
// digit's BCD value once its pattern has dwelt long enough, and flags bad codes.
module seg_scan_decoder #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   digit_bcd,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  err_pattern,
    output logic                  err_anode,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] AN_BLANK = {DIGITS{1'b1}};
    localparam logic [6:0]        SEG_OFF  = 7'h7f;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    logic [6:0]        s_seg_q, s_seg_d, p_seg_q, p_seg_d;
    logic [DIGITS-1:0] s_an_q, s_an_d, p_an_q, p_an_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        state_q, state_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [DIGITS-1:0] valid_q, valid_d, seen_q, seen_d;
    logic              err_pattern_q, err_pattern_d;
    logic              err_anode_q, err_anode_d;
    logic              frame_done_q, frame_done_d;

    logic              changed, blank, one_hot, evaluate, capture, dec_ok;
    logic [DIGITS-1:0] low;
    logic [3:0]        dec_val;

    // Segment pattern to BCD; anything not in the encoder's table is illegal.
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'd0;
        case (s_seg_q)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // Dwell tracking and scan FSM.
    always_comb begin
        s_seg_d  = seg_in;
        s_an_d   = an_in;
        p_seg_d  = s_seg_q;
        p_an_d   = s_an_q;
        changed  = {s_seg_q, s_an_q} != {p_seg_q, p_an_q};
        blank    = s_an_q == AN_BLANK;
        low      = ~s_an_q;
        one_hot  = (low != '0) && ((low & (low - DIGITS'(1))) == '0);
        state_d  = state_q;
        evaluate = 1'b0;

        if (changed)
            cnt_d = CNT_W'(1);
        else if (cnt_q >= CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (!blank)
                    state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (blank)
                    state_d = ST_IDLE;
                else if (!changed && cnt_q == CNT_MAX) begin
                    evaluate = 1'b1;
                    state_d  = ST_HELD;
                end
            end
            ST_HELD: begin
                if (changed)
                    state_d = blank ? ST_IDLE : ST_SETTLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Evaluation results: capture, error pulses and frame tracking.
    always_comb begin
        bcd_d         = bcd_q;
        valid_d       = valid_q;
        seen_d        = seen_q;
        frame_done_d  = 1'b0;
        capture       = evaluate && one_hot && dec_ok;
        err_anode_d   = evaluate && !one_hot;
        err_pattern_d = evaluate && one_hot && !dec_ok;

        if (capture) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (low[i])
                    bcd_d[4*i +: 4] = dec_val;
            end
            valid_d = valid_q | low;
            // A completed frame restarts the seen mask on the same edge.
            if ((seen_q | low) == AN_BLANK) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d = seen_q | low;
            end
        end else if (err_pattern_d) begin
            valid_d = valid_q & ~low;
        end
    end

    // Input samples reset to a blank bus so the first real sample counts as a change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg_q       <= SEG_OFF;
            s_an_q        <= AN_BLANK;
            p_seg_q       <= SEG_OFF;
            p_an_q        <= AN_BLANK;
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            bcd_q         <= '0;
            valid_q       <= '0;
            seen_q        <= '0;
            err_pattern_q <= 1'b0;
            err_anode_q   <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            s_seg_q       <= s_seg_d;
            s_an_q        <= s_an_d;
            p_seg_q       <= p_seg_d;
            p_an_q        <= p_an_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            bcd_q         <= bcd_d;
            valid_q       <= valid_d;
            seen_q        <= seen_d;
            err_pattern_q <= err_pattern_d;
            err_anode_q   <= err_anode_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign digit_bcd   = bcd_q;
    assign digit_valid = valid_q;
    assign err_pattern = err_pattern_q;
    assign err_anode   = err_anode_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed checks of seg_scan_decoder against a run-length based
// reference model of the display bus.
module tb_seg_scan_decoder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digit_bcd;
    logic [3:0]  digit_valid;
    logic        err_pattern, err_anode, frame_done;

    int checks = 0;
    int errors = 0;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
        .digit_bcd(digit_bcd), .digit_valid(digit_valid),
        .err_pattern(err_pattern), .err_anode(err_anode), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: a bus value held for STABLE+1 consecutive input edges is
    // evaluated once, with the result visible after the following edge.
    logic [15:0] m_bcd;
    logic [3:0]  m_valid, m_seen;
    logic        m_errp, m_erra, m_frame;
    int          run_len;
    logic [10:0] last_in;

    task automatic model_eval(input logic [6:0] seg, input logic [3:0] an);
        int lows, idx, val;
        lows = 0; idx = 0; val = -1;
        for (int i = 0; i < 4; i++) if (!an[i]) begin lows++; idx = i; end
        if (lows > 1) m_erra = 1'b1;
        else begin
            for (int v = 0; v < 10; v++) if (pat[v] == seg) val = v;
            if (val >= 0) begin
                m_bcd[4*idx +: 4] = 4'(val);
                m_valid[idx] = 1'b1;
                m_seen[idx]  = 1'b1;
                if (m_seen == 4'hF) begin m_frame = 1'b1; m_seen = 4'h0; end
            end else begin
                m_errp = 1'b1;
                m_valid[idx] = 1'b0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bcd = '0; m_valid = '0; m_seen = '0;
            m_errp = 0; m_erra = 0; m_frame = 0;
            run_len = 0; last_in = '0;
        end else begin
            m_errp = 0; m_erra = 0; m_frame = 0;
            if (run_len == int'(STABLE) + 1 && last_in[3:0] != 4'hF)
                model_eval(last_in[10:4], last_in[3:0]);
            if (run_len > 0 && {seg_in, an_in} == last_in) begin
                if (run_len < 1000) run_len++;
            end else run_len = 1;
            last_in = {seg_in, an_in};
        end
    end

    task automatic do_reset();
        rst = 1'b1; seg_in = 7'h7f; an_in = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [3:0] sel(input int d);
        logic [3:0] m;
        m = 4'hF;
        m[d] = 1'b0;
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1; seg_in = 7'b0100100; an_in = 4'hE;
        #1;
        checks++;
        if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== 23'd0) begin
            errors++; $display("FAIL reset_async: got %h required 0", {digit_bcd, digit_valid, err_pattern, err_anode, frame_done});
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== 23'd0) begin
            errors++; $display("FAIL reset_held: got %h required 0", {digit_bcd, digit_valid, err_pattern, err_anode, frame_done});
        end
    endtask

    task automatic test_single_capture();
        int first_valid, updates;
        logic [19:0] prev;
        do_reset();
        first_valid = -1; updates = 0; prev = {digit_bcd, digit_valid};
        seg_in = 7'b0100100; an_in = 4'hE;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== {m_bcd, m_valid, m_errp, m_erra, m_frame}) begin
                errors++; $display("FAIL single cyc%0d: got %h required %h", c,
                    {digit_bcd, digit_valid, err_pattern, err_anode, frame_done}, {m_bcd, m_valid, m_errp, m_erra, m_frame});
            end
            if (err_pattern || err_anode) updates += 100;
            if ({digit_bcd, digit_valid} != prev) updates++;
            if (digit_valid[0] && first_valid < 0) first_valid = c;
            prev = {digit_bcd, digit_valid};
        end
        checks++;
        if (first_valid != int'(STABLE) + 1) begin
            errors++; $display("FAIL single_latency: got edge %0d required %0d", first_valid, STABLE + 1);
        end
        checks++;
        if (digit_bcd[3:0] !== 4'd2 || digit_valid !== 4'b0001 || updates != 1) begin
            errors++; $display("FAIL single_final: got bcd %h valid %b updates %0d required 2 0001 1", digit_bcd, digit_valid, updates);
        end
    endtask

    task automatic test_dwell_restart();
        logic saw4;
        do_reset();
        saw4 = 1'b0;
        an_in = 4'hD;
        for (int c = 0; c < 16; c++) begin
            seg_in = (c < 3) ? 7'b0011001 : 7'b0010010;
            @(posedge clk); #1;
            checks++;
            if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== {m_bcd, m_valid, m_errp, m_erra, m_frame}) begin
                errors++; $display("FAIL restart cyc%0d: got %h required %h", c,
                    {digit_bcd, digit_valid, err_pattern, err_anode, frame_done}, {m_bcd, m_valid, m_errp, m_erra, m_frame});
            end
            if (digit_valid[1] && digit_bcd[7:4] == 4'd4) saw4 = 1'b1;
        end
        checks++;
        if (digit_bcd[7:4] !== 4'd5 || digit_valid !== 4'b0010 || saw4) begin
            errors++; $display("FAIL restart_final: got bcd %h valid %b saw4 %b required 5 0010 0", digit_bcd[7:4], digit_valid, saw4);
        end
    endtask

    task automatic test_scan();
        int vals [4] = '{1, 9, 7, 0};
        int frames, frame_t, t, t3;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            frames = 0; frame_t = -1; t = 0; t3 = 0;
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 8; c++) begin
                    seg_in = (c < 6) ? pat[vals[d]] : 7'h7f;
                    an_in  = (c < 6) ? sel(d) : 4'hF;
                    if (d == 3 && c == 0) t3 = t;
                    @(posedge clk); #1;
                    checks++;
                    if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== {m_bcd, m_valid, m_errp, m_erra, m_frame}) begin
                        errors++; $display("FAIL scan p%0d t%0d: got %h required %h", pass, t,
                            {digit_bcd, digit_valid, err_pattern, err_anode, frame_done}, {m_bcd, m_valid, m_errp, m_erra, m_frame});
                    end
                    if (frame_done) begin frames++; frame_t = t; end
                    t++;
                end
            end
            checks++;
            if (digit_bcd !== 16'h0791 || digit_valid !== 4'hF || frames != 1 || frame_t != t3 + int'(STABLE) + 1) begin
                errors++; $display("FAIL scan_frame p%0d: got bcd %h valid %h frames %0d at %0d required 0791 f 1 at %0d",
                    pass, digit_bcd, digit_valid, frames, frame_t, t3 + int'(STABLE) + 1);
            end
        end
    endtask

    task automatic test_pattern_error();
        int perr, aerr;
        do_reset();
        perr = 0; aerr = 0;
        an_in = 4'hB;
        for (int c = 0; c < 18; c++) begin
            seg_in = (c < 7) ? 7'b0000000 : 7'b1111111;
            @(posedge clk); #1;
            checks++;
            if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== {m_bcd, m_valid, m_errp, m_erra, m_frame}) begin
                errors++; $display("FAIL pattern cyc%0d: got %h required %h", c,
                    {digit_bcd, digit_valid, err_pattern, err_anode, frame_done}, {m_bcd, m_valid, m_errp, m_erra, m_frame});
            end
            if (err_pattern) perr++;
            if (err_anode) aerr++;
            if (c == 6 && (digit_valid !== 4'b0100 || digit_bcd[11:8] !== 4'd8)) begin
                errors++; $display("FAIL pattern_pre: got valid %b bcd %h required 0100 8", digit_valid, digit_bcd[11:8]);
            end
        end
        checks++;
        if (perr != 1 || aerr != 0 || digit_valid[2] !== 1'b0 || digit_bcd[11:8] !== 4'd8) begin
            errors++; $display("FAIL pattern_final: got perr %0d aerr %0d valid %b bcd %h required 1 0 0 8",
                perr, aerr, digit_valid[2], digit_bcd[11:8]);
        end
    endtask

    task automatic test_anode_error();
        int aerr, perr, frames;
        do_reset();
        aerr = 0; perr = 0; frames = 0;
        an_in = 4'hC; seg_in = pat[3];
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== {m_bcd, m_valid, m_errp, m_erra, m_frame}) begin
                errors++; $display("FAIL anode cyc%0d: got %h required %h", c,
                    {digit_bcd, digit_valid, err_pattern, err_anode, frame_done}, {m_bcd, m_valid, m_errp, m_erra, m_frame});
            end
            if (err_anode) aerr++;
            if (err_pattern) perr++;
        end
        checks++;
        if (aerr != 1 || perr != 0 || digit_bcd !== 16'h0 || digit_valid !== 4'h0) begin
            errors++; $display("FAIL anode_final: got aerr %0d perr %0d bcd %h valid %h required 1 0 0 0", aerr, perr, digit_bcd, digit_valid);
        end
        for (int r = 1; r <= 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                seg_in = (c < 6) ? pat[r] : 7'h7f;
                an_in  = (c < 6) ? 4'hE : 4'hF;
                @(posedge clk); #1;
                if (frame_done) frames++;
            end
        end
        checks++;
        if (frames != 0 || digit_valid !== 4'b0001 || digit_bcd[3:0] !== 4'd4) begin
            errors++; $display("FAIL repeat_digit0: got frames %0d valid %b bcd %h required 0 0001 4", frames, digit_valid, digit_bcd[3:0]);
        end
    endtask

    task automatic test_reset_mid();
        int first_valid;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            seg_in = (c < 6) ? pat[7] : 7'h7f;
            an_in  = (c < 6) ? 4'hE : 4'hF;
            @(posedge clk); #1;
        end
        checks++;
        if (digit_valid !== 4'b0001 || digit_bcd[3:0] !== 4'd7) begin
            errors++; $display("FAIL mid_pre: got valid %b bcd %h required 0001 7", digit_valid, digit_bcd[3:0]);
        end
        seg_in = pat[6]; an_in = 4'hD;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== 23'd0) begin
            errors++; $display("FAIL mid_async: got %h required 0", {digit_bcd, digit_valid, err_pattern, err_anode, frame_done});
        end
        @(negedge clk);
        rst = 1'b0;
        first_valid = -1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== {m_bcd, m_valid, m_errp, m_erra, m_frame}) begin
                errors++; $display("FAIL mid cyc%0d: got %h required %h", k,
                    {digit_bcd, digit_valid, err_pattern, err_anode, frame_done}, {m_bcd, m_valid, m_errp, m_erra, m_frame});
            end
            if (digit_valid[1] && first_valid < 0) first_valid = k;
        end
        checks++;
        if (first_valid != int'(STABLE) + 1 || digit_bcd[7:4] !== 4'd6 || digit_valid !== 4'b0010) begin
            errors++; $display("FAIL mid_recapture: got edge %0d bcd %h valid %b required %0d 6 0010",
                first_valid, digit_bcd[7:4], digit_valid, STABLE + 1);
        end
    endtask

    task automatic test_random();
        int dwell, gap, pick;
        logic [6:0] s;
        logic [3:0] a;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            pick = $urandom_range(0, 99);
            s = (pick < 75) ? pat[$urandom_range(0, 9)] : 7'($urandom);
            pick = $urandom_range(0, 99);
            if (pick < 70) a = sel($urandom_range(0, 3));
            else if (pick < 85) a = 4'hF;
            else a = 4'($urandom);
            dwell = $urandom_range(1, 8);
            gap = $urandom_range(0, 3);
            for (int c = 0; c < dwell + gap; c++) begin
                seg_in = (c < dwell) ? s : 7'h7f;
                an_in  = (c < dwell) ? a : 4'hF;
                @(posedge clk); #1;
                checks++;
                if ({digit_bcd, digit_valid, err_pattern, err_anode, frame_done} !== {m_bcd, m_valid, m_errp, m_erra, m_frame}) begin
                    errors++; $display("FAIL random n%0d c%0d: got %h required %h", n, c,
                        {digit_bcd, digit_valid, err_pattern, err_anode, frame_done}, {m_bcd, m_valid, m_errp, m_erra, m_frame});
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; seg_in = 7'h7f; an_in = 4'hF;
        test_reset();
        test_single_capture();
        test_dwell_restart();
        test_scan();
        test_pattern_error();
        test_anode_error();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
